// File: rtl/mfp_adc_max10_scan_ctrl.sv
// Scan sequencer for the MAX10 modular ADC command/response streams.
// Walks a channel mask one command at a time and posts each result, with timeout and mismatch flags.
//   state    | meaning
//   IDLE     | waiting for start pulse or qualified trigger edge
//   CMD      | command presented, waiting for ADC_C_Ready
//   WAIT_RSP | command accepted, waiting for response or timeout
module mfp_adc_max10_scan_ctrl #(
  parameter int NUM_CH  = 17,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [NUM_CH-1:0] cfg_mask,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_continuous,
  input  logic              cfg_trig_en,
  input  logic              irq_clear,
  input  logic              irq_clear_err,
  input  logic              ADC_Trigger,
  output logic              ADC_C_Valid,
  output logic [4:0]        ADC_C_Channel,
  output logic              ADC_C_SOP,
  output logic              ADC_C_EOP,
  input  logic              ADC_C_Ready,
  input  logic              ADC_R_Valid,
  input  logic [4:0]        ADC_R_Channel,
  input  logic [11:0]       ADC_R_Data,
  output logic              result_wr,
  output logic [4:0]        result_channel,
  output logic [11:0]       result_data,
  output logic              busy,
  output logic              scan_done,
  output logic              err_mismatch,
  output logic              err_timeout,
  output logic              irq
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  TC  = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;

  state_t            state;
  logic [NUM_CH-1:0] work_mask;
  logic [NUM_CH-1:0] reload_mask;
  logic [4:0]        ch;
  logic              c_valid;
  logic [CNT_W-1:0]  tcnt;
  logic              stop_pending;
  logic              trig_s1, trig_s2, trig_d;

  logic              start_evt;
  logic              stop_now;
  logic [NUM_CH-1:0] remain;

  function automatic logic [4:0] lowest(input logic [NUM_CH-1:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  always_comb begin
    start_evt = cfg_start | (cfg_trig_en & trig_s2 & ~trig_d);
    stop_now  = stop_pending | cfg_stop;
    remain    = work_mask & ~(ONE << ch);
  end

  assign ADC_C_Valid   = c_valid;
  assign ADC_C_SOP     = c_valid;
  assign ADC_C_EOP     = c_valid;
  assign ADC_C_Channel = ch;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state          <= S_IDLE;
      work_mask      <= '0;
      reload_mask    <= '0;
      ch             <= '0;
      c_valid        <= 1'b0;
      tcnt           <= '0;
      stop_pending   <= 1'b0;
      trig_s1        <= 1'b0;
      trig_s2        <= 1'b0;
      trig_d         <= 1'b0;
      result_wr      <= 1'b0;
      result_channel <= '0;
      result_data    <= '0;
      scan_done      <= 1'b0;
      err_mismatch   <= 1'b0;
      err_timeout    <= 1'b0;
      irq            <= 1'b0;
    end else begin
      trig_s1   <= ADC_Trigger;
      trig_s2   <= trig_s1;
      trig_d    <= trig_s2;
      result_wr <= 1'b0;
      scan_done <= 1'b0;
      // Clears come first so a same-cycle set below takes priority.
      if (irq_clear) irq <= 1'b0;
      if (irq_clear_err) begin
        err_mismatch <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (state != S_IDLE && cfg_stop) stop_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_evt && cfg_mask != '0) begin
            work_mask   <= cfg_mask;
            reload_mask <= cfg_mask;
            ch          <= lowest(cfg_mask);
            c_valid     <= 1'b1;
            state       <= S_CMD;
          end
        end
        S_CMD: begin
          if (ADC_C_Ready) begin
            c_valid <= 1'b0;
            tcnt    <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ADC_R_Valid || tcnt == TC) begin
            result_wr      <= 1'b1;
            result_channel <= ch;
            if (ADC_R_Valid) begin
              result_data <= ADC_R_Data;
              if (ADC_R_Channel != ch) err_mismatch <= 1'b1;
            end else begin
              result_data <= '0;
              err_timeout <= 1'b1;
            end
            if (remain != '0 && !stop_now) begin
              work_mask <= remain;
              ch        <= lowest(remain);
              c_valid   <= 1'b1;
              state     <= S_CMD;
            end else if (remain == '0) begin
              scan_done <= 1'b1;
              irq       <= 1'b1;
              if (cfg_continuous && !stop_now) begin
                work_mask <= reload_mask;
                ch        <= lowest(reload_mask);
                c_valid   <= 1'b1;
                state     <= S_CMD;
              end else begin
                work_mask    <= '0;
                stop_pending <= 1'b0;
                state        <= S_IDLE;
              end
            end else begin
              work_mask    <= remain;
              stop_pending <= 1'b0;
              state        <= S_IDLE;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
